// File: rtl/stream_demux_1ton.sv
// stream_demux_1ton: registered 1-to-N packet-stream demultiplexer.
// The channel select is locked on the first beat of each packet, and every
// beat of that packet is steered through one shared output register to the
// locked channel. A packet whose select is out of range is consumed and
// discarded, and the saturating drop counter records it.
module stream_demux_1ton #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 8,
    parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [SEL_W-1:0]  s_sel,
    input  logic              s_last,
    output logic [NUM_CH-1:0] m_valid,
    input  logic [NUM_CH-1:0] m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [CNT_W-1:0]  drop_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        DROP = 2'd2
    } state_t;

    // One bit wider than the select, so NUM_CH = 2^SEL_W is still representable.
    localparam logic [SEL_W:0] NUM_CH_L = (SEL_W+1)'(NUM_CH);

    state_t              state, state_nxt;
    logic                out_vld;
    logic [SEL_W-1:0]    out_ch;
    logic [DATA_W-1:0]   out_data;
    logic                out_last;
    logic [SEL_W-1:0]    lock_ch;

    logic                drain_rdy;
    logic                drain;
    logic                can_load;
    logic                ready_int;
    logic                accept;
    logic                sel_ok;
    logic                load;
    logic                lock_set;
    logic [SEL_W-1:0]    load_ch;
    logic                drop_inc;

    // Pick the ready of the channel currently holding the output beat.
    // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        drain_rdy = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (out_ch == SEL_W'(i)) drain_rdy = m_ready[i];
        end
    end

    // Decode the shared output register into the one-hot channel valids.
    always_comb begin
        m_valid = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_valid[i] = out_vld && (out_ch == SEL_W'(i));
        end
    end

    assign drain     = out_vld && drain_rdy;
    assign can_load  = !out_vld || drain;
    // Beats being discarded never wait on the output register.
    assign ready_int = (state == DROP) ? 1'b1 : can_load;
    assign s_ready   = ready_int && rst_n;
    assign accept    = s_valid && s_ready;
    assign sel_ok    = ({1'b0, s_sel} < NUM_CH_L);

    assign m_data = out_data;
    assign m_last = out_last;

    // Next-state logic and per-beat steering decisions.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        lock_set  = 1'b0;
        load_ch   = lock_ch;
        drop_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (sel_ok) begin
                        load     = 1'b1;
                        lock_set = 1'b1;
                        load_ch  = s_sel;
                        if (!s_last) state_nxt = PKT;
                    end else begin
                        drop_inc = 1'b1;
                        if (!s_last) state_nxt = DROP;
                    end
                end
            end
            PKT: begin
                if (accept) begin
                    load = 1'b1;
                    if (s_last) state_nxt = IDLE;
                end
            end
            DROP: begin
                if (accept && s_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset abandons any packet in flight.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Output register: load an accepted beat, else release it once drained.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_ch   <= '0;
            out_data <= '0;
            out_last <= 1'b0;
        end else if (load) begin
            out_vld  <= 1'b1;
            out_ch   <= load_ch;
            out_data <= s_data;
            out_last <= s_last;
        end else if (drain) begin
            out_vld  <= 1'b0;
        end
    end

    // Locked channel for the remaining beats of the current packet.
    always_ff @(posedge clk) begin
        if (!rst_n)        lock_ch <= '0;
        else if (lock_set) lock_ch <= s_sel;
    end

    // Saturating count of dropped packets.
    always_ff @(posedge clk) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if (drop_inc && (drop_cnt != {CNT_W{1'b1}}))
            drop_cnt <= drop_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Directed testbench for stream_demux_1ton: an 8-channel instance covers
// steering, select lock, backpressure, reset and non-active ready. A 6-channel
// instance with a 4-bit counter covers the drop path and counter saturation.
module tb_stream_demux_1ton;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 8-channel instance
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic [2:0]  s_sel;
    logic        s_last;
    logic [7:0]  m_valid;
    logic [7:0]  m_ready;
    logic [7:0]  m_data;
    logic        m_last;
    logic [15:0] drop_cnt;

    // 6-channel instance
    logic        rst6_n;
    logic        v6;
    logic        r6;
    logic [7:0]  d6;
    logic [2:0]  sel6;
    logic        l6;
    logic [5:0]  mv6;
    logic [5:0]  mr6;
    logic [7:0]  md6;
    logic        ml6;
    logic [3:0]  dc6;

    stream_demux_1ton #(.DATA_W(8), .NUM_CH(8), .CNT_W(16)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_sel(s_sel), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .drop_cnt(drop_cnt)
    );

    stream_demux_1ton #(.DATA_W(8), .NUM_CH(6), .CNT_W(4)) dut6 (
        .clk(clk), .rst_n(rst6_n),
        .s_valid(v6), .s_ready(r6), .s_data(d6),
        .s_sel(sel6), .s_last(l6),
        .m_valid(mv6), .m_ready(mr6), .m_data(md6),
        .m_last(ml6), .drop_cnt(dc6)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic v, input logic [2:0] sel, input logic [7:0] d, input logic l);
        s_valid = v;
        s_sel   = sel;
        s_data  = d;
        s_last  = l;
    endtask

    task automatic drive6(input logic v, input logic [2:0] sel, input logic [7:0] d, input logic l);
        v6   = v;
        sel6 = sel;
        d6   = d;
        l6   = l;
    endtask

    initial begin
        rst_n = 1'b0;  m_ready = 8'hFF;  drive8(1'b0, 3'd0, 8'h00, 1'b0);
        rst6_n = 1'b0; mr6 = 6'h3F;      drive6(1'b0, 3'd0, 8'h00, 1'b0);
        tick();
        tick();

        // Reset state
        check("rst_m_valid",  32'(m_valid),  32'h0);
        check("rst_m_data",   32'(m_data),   32'h0);
        check("rst_m_last",   32'(m_last),   32'h0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        check("rst_s_ready",  32'(s_ready),  32'h0);
        check("rst6_s_ready", 32'(r6),       32'h0);
        rst_n  = 1'b1;
        rst6_n = 1'b1;
        #1;
        check("rel_s_ready", 32'(s_ready), 32'h1);

        // Basic steer: single-beat packets to every channel at full rate
        for (int i = 0; i < 8; i++) begin
            drive8(1'b1, 3'(i), 8'(8'hA0 + i), 1'b1);
            #1;
            check($sformatf("steer_s_ready_%0d", i), 32'(s_ready), 32'h1);
            tick();
            check($sformatf("steer_m_valid_%0d", i), 32'(m_valid), 32'(1 << i));
            check($sformatf("steer_m_data_%0d", i),  32'(m_data),  32'(8'hA0 + i));
            check($sformatf("steer_m_last_%0d", i),  32'(m_last),  32'h1);
        end
        drive8(1'b0, 3'd0, 8'h00, 1'b0);
        tick();
        check("steer_idle_m_valid", 32'(m_valid), 32'h0);

        // Select lock: 4-beat packet to ch 5 with s_sel changing every beat
        drive8(1'b1, 3'd5, 8'h50, 1'b0); tick();
        check("lock_b0_m_valid", 32'(m_valid), 32'h20);
        check("lock_b0_m_data",  32'(m_data),  32'h50);
        check("lock_b0_m_last",  32'(m_last),  32'h0);
        drive8(1'b1, 3'd2, 8'h51, 1'b0); tick();
        check("lock_b1_m_valid", 32'(m_valid), 32'h20);
        check("lock_b1_m_data",  32'(m_data),  32'h51);
        check("lock_b1_m_last",  32'(m_last),  32'h0);
        drive8(1'b1, 3'd7, 8'h52, 1'b0); tick();
        check("lock_b2_m_valid", 32'(m_valid), 32'h20);
        check("lock_b2_m_data",  32'(m_data),  32'h52);
        drive8(1'b1, 3'd0, 8'h53, 1'b1); tick();
        check("lock_b3_m_valid", 32'(m_valid), 32'h20);
        check("lock_b3_m_data",  32'(m_data),  32'h53);
        check("lock_b3_m_last",  32'(m_last),  32'h1);
        drive8(1'b1, 3'd2, 8'h77, 1'b1); tick();
        check("lock_next_m_valid", 32'(m_valid), 32'h04);
        check("lock_next_m_data",  32'(m_data),  32'h77);
        drive8(1'b0, 3'd0, 8'h00, 1'b0); tick();
        check("lock_idle_m_valid", 32'(m_valid), 32'h0);

        // Backpressure: ch 3 stalls for 5 edges mid-packet
        drive8(1'b1, 3'd3, 8'd10, 1'b0); tick();
        check("bp_b0_m_valid", 32'(m_valid), 32'h08);
        check("bp_b0_m_data",  32'(m_data),  32'd10);
        m_ready = 8'hF7;
        drive8(1'b1, 3'd1, 8'd11, 1'b0);
        #1;
        check("bp_s_ready_low", 32'(s_ready), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_hold_m_valid_%0d", i), 32'(m_valid), 32'h08);
            check($sformatf("bp_hold_m_data_%0d", i),  32'(m_data),  32'd10);
            check($sformatf("bp_hold_s_ready_%0d", i), 32'(s_ready), 32'h0);
        end
        m_ready = 8'hFF;
        #1;
        check("bp_s_ready_rise", 32'(s_ready), 32'h1);
        tick();
        check("bp_b1_m_valid", 32'(m_valid), 32'h08);
        check("bp_b1_m_data",  32'(m_data),  32'd11);
        check("bp_b1_m_last",  32'(m_last),  32'h0);
        drive8(1'b1, 3'd6, 8'd12, 1'b1); tick();
        check("bp_b2_m_valid", 32'(m_valid), 32'h08);
        check("bp_b2_m_data",  32'(m_data),  32'd12);
        check("bp_b2_m_last",  32'(m_last),  32'h1);
        drive8(1'b0, 3'd0, 8'h00, 1'b0); tick();
        check("bp_idle_m_valid", 32'(m_valid), 32'h0);

        // Non-active ready: only ch 2 is stalled while it holds the beat
        drive8(1'b1, 3'd2, 8'h22, 1'b1); tick();
        check("na_m_valid", 32'(m_valid), 32'h04);
        m_ready = 8'hFB;
        drive8(1'b1, 3'd1, 8'h33, 1'b1);
        #1;
        check("na_s_ready", 32'(s_ready), 32'h0);
        tick();
        check("na_hold_m_valid", 32'(m_valid), 32'h04);
        check("na_hold_m_data",  32'(m_data),  32'h22);
        m_ready = 8'hFF;
        #1;
        check("na_s_ready_rise", 32'(s_ready), 32'h1);
        tick();
        check("na_next_m_valid", 32'(m_valid), 32'h02);
        check("na_next_m_data",  32'(m_data),  32'h33);
        drive8(1'b0, 3'd0, 8'h00, 1'b0); tick();
        check("na_idle_m_valid", 32'(m_valid), 32'h0);

        // Reset mid-packet: beat 1 of a 4-beat packet to ch 4 is held, reset during beat 2
        drive8(1'b1, 3'd4, 8'h40, 1'b0); tick();
        check("rmp_b0_m_valid", 32'(m_valid), 32'h10);
        m_ready = 8'h00;
        rst_n   = 1'b0;
        drive8(1'b1, 3'd4, 8'h41, 1'b0);
        #1;
        check("rmp_s_ready_in_reset", 32'(s_ready), 32'h0);
        tick();
        check("rmp_m_valid",  32'(m_valid),  32'h0);
        check("rmp_m_data",   32'(m_data),   32'h0);
        check("rmp_drop_cnt", 32'(drop_cnt), 32'h0);
        rst_n   = 1'b1;
        m_ready = 8'hFF;
        drive8(1'b1, 3'd6, 8'h66, 1'b1); tick();
        check("rmp_next_m_valid", 32'(m_valid), 32'h40);
        check("rmp_next_m_data",  32'(m_data),  32'h66);
        check("rmp_next_m_last",  32'(m_last),  32'h1);
        drive8(1'b0, 3'd0, 8'h00, 1'b0); tick();
        check("rmp_idle_m_valid", 32'(m_valid), 32'h0);

        // Drop path (NUM_CH = 6): 3-beat packet with s_sel = 7
        drive6(1'b1, 3'd7, 8'h01, 1'b0);
        #1;
        check("drop_b0_s_ready", 32'(r6), 32'h1);
        tick();
        check("drop_b0_m_valid", 32'(mv6), 32'h0);
        check("drop_b0_cnt",     32'(dc6), 32'h1);
        drive6(1'b1, 3'd3, 8'h02, 1'b0);
        #1;
        check("drop_b1_s_ready", 32'(r6), 32'h1);
        tick();
        check("drop_b1_m_valid", 32'(mv6), 32'h0);
        drive6(1'b1, 3'd3, 8'h03, 1'b1);
        #1;
        check("drop_b2_s_ready", 32'(r6), 32'h1);
        tick();
        check("drop_b2_m_valid", 32'(mv6), 32'h0);
        check("drop_b2_cnt",     32'(dc6), 32'h1);
        drive6(1'b1, 3'd1, 8'h5A, 1'b1); tick();
        check("drop_next_m_valid", 32'(mv6), 32'h02);
        check("drop_next_m_data",  32'(md6), 32'h5A);
        check("drop_next_cnt",     32'(dc6), 32'h1);
        // Highest in-range select is steered, not dropped
        drive6(1'b1, 3'd5, 8'h5B, 1'b1); tick();
        check("drop_top_m_valid", 32'(mv6), 32'h20);
        check("drop_top_cnt",     32'(dc6), 32'h1);
        // s_sel = NUM_CH is the first out-of-range value; fill the counter to its maximum
        for (int i = 0; i < 14; i++) begin
            drive6(1'b1, (i % 2 == 0) ? 3'd6 : 3'd7, 8'(i), 1'b1);
            tick();
        end
        check("sat_full_cnt",     32'(dc6), 32'hF);
        check("sat_full_m_valid", 32'(mv6), 32'h0);
        drive6(1'b1, 3'd6, 8'hEE, 1'b1); tick();
        check("sat_hold_cnt", 32'(dc6), 32'hF);
        drive6(1'b0, 3'd0, 8'h00, 1'b0); tick();
        check("sat_idle_m_valid", 32'(mv6), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_demux_1ton.md
# stream_demux_1toN

Parametrised, registered 1-to-N packet-stream demultiplexer with valid/ready handshaking on every port. It is the successor to the fixed-width, purely combinational 1-to-8 demux: a select is locked per packet and beats are steered through a single output register to one of NUM_CH channels. Packets whose select is out of range are dropped and counted. It sits between a packet source and NUM_CH independent consumers.

## Interface
- DATA_W, 8, beat data width in bits (≥1)
- NUM_CH, 8, number of output channels (2..256)
- SEL_W, $clog2(NUM_CH) with a minimum of 1, select width
- CNT_W, 16, drop-counter width
- clk  in  1  sole clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid && s_ready
- s_data  in  DATA_W  input beat data
- s_sel  in  SEL_W  destination channel; sampled only on the first beat of a packet
- s_last  in  1  final beat of packet
- m_valid  out  NUM_CH  one-hot or zero; bit i means channel i holds a beat
- m_ready  in  NUM_CH  per-channel ready
- m_data  out  DATA_W  beat data, shared by all channels; qualified by m_valid[i]
- m_last  out  1  final-beat flag, shared by all channels
- drop_cnt  out  CNT_W  saturating count of dropped packets

## Operation
- **Output register:** out_vld, out_ch (SEL_W), out_data, out_last. m_valid[i] = out_vld && (out_ch == i). m_data = out_data. m_last = out_last.
- **Drain condition:** drain = out_vld && m_ready[out_ch]. Register load-enable: !out_vld || drain.
- **FSM:** IDLE, PKT, DROP. Reset state is IDLE.
- **IDLE** (waiting for a first beat):
  - s_ready = !out_vld || drain.
  - On accept with s_sel < NUM_CH: load the output register with ch = s_sel and lock_ch = s_sel. Next state is IDLE if s_last, otherwise PKT.
  - On accept with s_sel ≥ NUM_CH (only possible when NUM_CH is not a power of 2): the beat is consumed but not loaded, and drop_cnt increments. Next state is IDLE if s_last, otherwise DROP.
- **PKT:**
  - s_ready = !out_vld || drain.
  - s_sel is ignored. Each accepted beat loads with ch = lock_ch.
  - Accepting the s_last beat moves to IDLE.
- **DROP:**
  - s_ready = 1 and accepted beats are discarded.
  - Accepting the s_last beat moves to IDLE.
  - The output register keeps draining independently.
- **Output register update:** if accept-and-load, set out_vld = 1 and load the fields. Else if drain, clear out_vld. Otherwise hold.
- **drop_cnt:** saturates at 2^CNT_W−1 and never wraps.
- **Single-beat packets** (first beat with s_last = 1): no PKT or DROP visit.
- **m_ready on non-active channels** is ignored. m_ready may depend combinationally on m_valid.
- **Combinational path:** m_ready reaches s_ready combinationally. There is no path from s_valid to m_valid.

## Timing
- Latency: a beat accepted at edge k is visible on m_valid/m_data after edge k and drains at the first edge where m_ready[out_ch] = 1.
- Throughput: 1 beat per cycle when the active channel's m_ready is held high, including back-to-back packets to different channels.
- Reset (rst_n = 0 at an edge): the following clear at that edge regardless of handshakes, and a packet in flight is abandoned.
  - state = IDLE
  - out_vld = 0, m_valid = 0
  - out_data = 0, out_last = 0
  - out_ch = 0, lock_ch = 0
  - drop_cnt = 0
- During reset s_ready = 0. The first beat after reset release is treated as a packet's first beat.
- Holding rules:
  - out_data and out_ch hold while m_valid is high and not drained.
  - s_ready may deassert only as a function of the output register and m_ready.

## Test plan
- **Basic steer:** DATA_W = 8, NUM_CH = 8, all m_ready = 1. Send single-beat packets with s_sel = 0..7 and s_data = 8'hA0+sel. Required: m_valid = 1<<sel one cycle later with m_data = A0+sel and m_last = 1. Full rate, no bubbles.
- **Select lock:** 4-beat packet to ch 5 with s_sel changing every beat (5, 2, 7, 0). Required: all 4 beats appear on ch 5 only, m_last only on beat 4. The next packet with s_sel = 2 goes to ch 2.
- **Backpressure:** ch 3 m_ready = 0 for 5 cycles mid-packet. Required: s_ready = 0 after the register fills, m_data stable, no beat lost or duplicated. Sequence 10, 11, 12 is received intact after m_ready rises.
- **Drop path:** NUM_CH = 6. 3-beat packet with s_sel = 7, then a 1-beat packet with s_sel = 1. Required: s_ready = 1 throughout the drop, no m_valid for the dropped beats, drop_cnt = 1, the next packet reaches ch 1. Drive drop_cnt to 16'hFFFF, then one more drop: it stays FFFF.
- **Reset mid-packet:** rst_n = 0 for 1 cycle during beat 2 of a 4-beat packet to ch 4, with m_valid asserted. Required: m_valid = 0 and drop_cnt = 0 after the edge. The next beat (s_sel = 6) is treated as a first beat and steered to ch 6.
- **Non-active ready:** m_valid on ch 2 with m_ready[2] = 0 and all other m_ready = 1. Required: the beat holds and s_ready = 0.
